// File: rtl/btn_pkg.sv
// Shared constants, id width helper and event id type for the front-panel
// button controller.
package btn_pkg;

  localparam int unsigned DEF_TICK_DIV   = 100000;
  localparam int unsigned DEF_DELAY      = 20;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned MAX_ID_W       = 3;

  typedef logic [MAX_ID_W-1:0] evt_id_t;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_lane.sv
// One debounce lane: free-running 2-flop synchroniser, then a tick-enabled
// agreement counter that flips the level after DELAY disagreeing ticks.
module btn_debounce_lane
  import btn_pkg::*;
#(
  parameter int unsigned DELAY = DEF_DELAY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic [4:0] cnt_q, cnt_d;
  logic       flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    if (tick) begin
      if (sync2_q != level_q) begin
        if (cnt_q == 5'(DELAY - 1)) begin
          flip    = 1'b1;
          level_d = sync2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Combinational so the pending bit is set on the same edge the level rises.
  assign press = flip & sync2_q;
  assign level = level_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Front-panel controller: shared debounce tick, per-button press events,
// round-robin arbitration into a small event FIFO drained by valid/ready.
module button_event_arbiter
  import btn_pkg::*;
#(
  parameter  int unsigned N_BTN      = 5,
  parameter  int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter  int unsigned DELAY      = DEF_DELAY,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned ID_W       = id_w(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [TW-1:0]    tick_q, tick_d;
  logic             tick;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic             overflow_q, overflow_d;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_idx;
  logic [N_BTN-1:0] grant_oh;
  logic             can_push, push, pop;
  evt_id_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;

  assign tick   = (tick_q == TW'(TICK_DIV - 1));
  assign tick_d = tick ? '0 : tick_q + 1'b1;

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    btn_debounce_lane #(.DELAY(DELAY)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(press[i])
    );
  end

  assign evt_valid = (count_q != '0);
  assign evt_id    = evt_valid ? ID_W'(mem_q[rd_q]) : '0;
  assign pop       = evt_valid & evt_ready;
  assign can_push  = (count_q < CW'(FIFO_DEPTH)) || pop;
  assign push      = grant_valid;

  // Cyclic search from rr_q split into two fixed passes: [rr_q..N-1], then [0..rr_q-1].
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (can_push) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (!grant_valid && pending_q[i] && (ID_W'(i) >= rr_q)) begin
          grant_valid = 1'b1;
          grant_idx   = ID_W'(i);
        end
      end
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (!grant_valid && pending_q[i]) begin
          grant_valid = 1'b1;
          grant_idx   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    grant_oh   = grant_valid ? (N_BTN'(1) << grant_idx) : '0;
    pending_d  = (pending_q & ~grant_oh) | press;
    overflow_d = (|(press & pending_q & ~grant_oh)) | (overflow_q & ~ovf_clr);
    rr_d       = rr_q;
    if (grant_valid) begin
      rr_d = (grant_idx == ID_W'(N_BTN - 1)) ? '0 : grant_idx + 1'b1;
    end
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop  ? rd_q + 1'b1 : rd_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q     <= '0;
      pending_q  <= '0;
      rr_q       <= '0;
      overflow_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      mem_q      <= '{default: '0};
    end else begin
      tick_q     <= tick_d;
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      if (push) mem_q[wr_q] <= evt_id_t'(grant_idx);
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_button_event_arbiter;

  localparam int N  = 5;
  localparam int TD = 4;
  localparam int DL = 3;
  localparam int FD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic         evt_valid;
  logic [2:0]   evt_id;
  logic         evt_ready = 1'b0;
  logic         overflow;
  logic         ovf_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BTN(N),
    .TICK_DIV(TD),
    .DELAY(DL),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_id(evt_id),
    .evt_ready(evt_ready),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  // Reference model: raw delayed two edges, a history of s vectors sampled
  // at ticks (level flips when the last DL samples all disagree), a pending
  // set, a cyclic priority search and an event queue.
  int           m_phase;
  logic [N-1:0] m_s1, m_s2, m_lvl, m_pend;
  int           m_rr;
  int           m_q[$];
  logic         m_ovf;
  logic [N-1:0] m_hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0;
      m_rr = 0; m_ovf = 1'b0;
      m_q.delete();
      m_hist.delete();
    end else begin : step
      logic [N-1:0] prs;
      logic pop, can_push, stable, ovf_set;
      int g, idx;
      prs = '0;
      if (m_phase == TD - 1) begin
        m_hist.push_back(m_s2);
        if (m_hist.size() > DL) void'(m_hist.pop_front());
        if (m_hist.size() == DL) begin
          for (int i = 0; i < N; i++) begin
            stable = 1'b1;
            for (int k = 0; k < DL; k++) if (m_hist[k][i] == m_lvl[i]) stable = 1'b0;
            if (stable) begin
              if (!m_lvl[i]) prs[i] = 1'b1;
              m_lvl[i] = ~m_lvl[i];
            end
          end
        end
      end
      pop = (m_q.size() != 0) && evt_ready;
      can_push = (m_q.size() < FD) || pop;
      g = -1;
      if (can_push)
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (g < 0 && m_pend[idx]) g = idx;
        end
      ovf_set = 1'b0;
      for (int i = 0; i < N; i++) if (prs[i] && m_pend[i] && g != i) ovf_set = 1'b1;
      m_ovf = ovf_set | (m_ovf & ~ovf_clr);
      if (pop) void'(m_q.pop_front());
      if (g >= 0) begin
        m_q.push_back(g);
        m_pend[g] = 1'b0;
        m_rr = (g + 1) % N;
      end
      m_pend = m_pend | prs;
      m_s2 = m_s1;
      m_s1 = btn_raw;
      m_phase = (m_phase + 1) % TD;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; btn_raw = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_raw = '1; evt_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (btn_level !== '0 || evt_valid !== 1'b0 || evt_id !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got lvl=%b v=%b id=%0d ovf=%b, expected all 0", btn_level, evt_valid, evt_id, overflow);
    end
    btn_raw = '0; evt_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    int c, seen;
    do_reset();
    btn_raw = 5'b00100;
    c = 0;
    while (btn_level[2] !== 1'b1 && c < 40) begin @(negedge clk); c++; end
    n_checks++;
    if (btn_level !== 5'b00100 || c > 17) begin
      n_fail++;
      $display("FAIL clean_level: got lvl=%b after %0d cycles, expected 00100 within 17", btn_level, c);
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL clean_latency: got evt_valid=%b on level edge, expected 0", evt_valid);
    end
    @(negedge clk);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd2) begin
      n_fail++; $display("FAIL clean_event: got v=%b id=%0d, expected v=1 id=2", evt_valid, evt_id);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL clean_pop: got evt_valid=%b, expected 0", evt_valid);
    end
    btn_raw = '0;
    seen = 0;
    repeat (30) begin @(negedge clk); if (evt_valid === 1'b1) seen++; end
    n_checks++;
    if (seen != 0 || btn_level !== '0) begin
      n_fail++; $display("FAIL clean_release: got %0d events lvl=%b, expected 0 events lvl=0", seen, btn_level);
    end
  endtask

  task automatic test_glitch();
    int seen;
    do_reset();
    btn_raw = 5'b00010;
    repeat (2 * TD) @(negedge clk);
    btn_raw = '0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (btn_level[1] === 1'b1 || evt_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL glitch: got %0d level/event cycles ovf=%b, expected 0 and 0", seen, overflow);
    end
  endtask

  task automatic drain_expect(input string name, input int ids[$]);
    foreach (ids[k]) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_id !== 3'(ids[k])) begin
        n_fail++;
        $display("FAIL %s[%0d]: got v=%b id=%0d, expected v=1 id=%0d", name, k, evt_valid, evt_id, ids[k]);
      end
      evt_ready = 1'b1;
      @(negedge clk);
    end
    evt_ready = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_empty: got evt_valid=%b, expected 0", name, evt_valid);
    end
  endtask

  task automatic wait_valid(input string name);
    int c;
    c = 0;
    while (evt_valid !== 1'b1 && c < 40) begin @(negedge clk); c++; end
    n_checks++;
    if (evt_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_timeout: got evt_valid=%b after %0d cycles, expected 1", name, evt_valid, c);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    btn_raw = 5'b11001;
    wait_valid("simul_a");
    repeat (4) @(negedge clk);
    drain_expect("simul_a", '{0, 3, 4});
    btn_raw = '0;
    repeat (25) @(negedge clk);
    btn_raw = 5'b00001;
    wait_valid("simul_b");
    drain_expect("simul_b", '{0});
    btn_raw = '0;
    repeat (25) @(negedge clk);
    btn_raw = 5'b01001;
    wait_valid("simul_c");
    repeat (3) @(negedge clk);
    drain_expect("simul_c", '{3, 0});
  endtask

  task automatic test_back_to_back();
    int stable_bad;
    do_reset();
    btn_raw = 5'b11111;
    repeat (25) @(negedge clk);
    stable_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (evt_valid !== 1'b1 || evt_id !== 3'd0) stable_bad++;
    end
    n_checks++;
    if (stable_bad != 0) begin
      n_fail++; $display("FAIL full_hold: got %0d unstable cycles (v=%b id=%0d), expected 0", stable_bad, evt_valid, evt_id);
    end
    drain_expect("full_drain", '{0, 1, 2, 3, 4});
  endtask

  task automatic test_overflow();
    do_reset();
    btn_raw = 5'b11101;
    repeat (25) @(negedge clk);
    btn_raw = 5'b11111;
    repeat (25) @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_early: got overflow=%b, expected 0", overflow);
    end
    btn_raw = 5'b11101;
    repeat (25) @(negedge clk);
    btn_raw = 5'b11111;
    repeat (25) @(negedge clk);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got overflow=%b, expected 1", overflow);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr: got overflow=%b, expected 0", overflow);
    end
    drain_expect("ovf_drain", '{0, 2, 3, 4, 1});
  endtask

  task automatic test_reset_mid();
    int cnt, last_id;
    do_reset();
    btn_raw = 5'b00111;
    repeat (25) @(negedge clk);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd0) begin
      n_fail++; $display("FAIL mid_queued: got v=%b id=%0d, expected v=1 id=0", evt_valid, evt_id);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (btn_level !== '0 || evt_valid !== 1'b0 || evt_id !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got lvl=%b v=%b id=%0d ovf=%b, expected all 0", btn_level, evt_valid, evt_id, overflow);
    end
    @(negedge clk);
    btn_raw = 5'b00100;
    @(negedge clk);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    cnt = 0; last_id = -1;
    repeat (40) begin
      @(negedge clk);
      if (evt_valid === 1'b1) begin cnt++; last_id = int'(evt_id); end
    end
    evt_ready = 1'b0;
    n_checks++;
    if (cnt != 1 || last_id != 2) begin
      n_fail++; $display("FAIL mid_requalify: got %0d events last id=%0d, expected 1 event id=2", cnt, last_id);
    end
  endtask

  task automatic test_random();
    int exp_id;
    do_reset();
    repeat (1200) begin
      @(negedge clk);
      n_checks++;
      if (btn_level !== m_lvl) begin
        n_fail++; $display("FAIL rand_level: got %b expected %b", btn_level, m_lvl);
      end
      n_checks++;
      if (evt_valid !== (m_q.size() != 0)) begin
        n_fail++; $display("FAIL rand_valid: got %b expected %0d", evt_valid, m_q.size() != 0);
      end
      exp_id = (m_q.size() != 0) ? m_q[0] : 0;
      n_checks++;
      if (evt_id !== 3'(exp_id)) begin
        n_fail++; $display("FAIL rand_id: got %0d expected %0d", evt_id, exp_id);
      end
      n_checks++;
      if (overflow !== m_ovf) begin
        n_fail++; $display("FAIL rand_ovf: got %b expected %b", overflow, m_ovf);
      end
      if ($urandom_range(0, 11) == 0) btn_raw = btn_raw ^ (5'b00001 << $urandom_range(0, N - 1));
      evt_ready = ($urandom_range(0, 3) == 0);
      ovf_clr   = ($urandom_range(0, 49) == 0);
    end
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
